// File: rtl/fe25519_pkg.sv
// ---------------------------------------------------------------------------
// fe25519_pkg
// Shared constants for GF(2^255-19) arithmetic used by the curve25519 ladder
// and the inversion sequencer.
//   P            field prime 2^255-19
//   P_MINUS_TWO  inversion exponent (Fermat)
//   FOLD_C       2^255 mod P, used to fold high bits back into the low word
//   K            cycles per multiplier pipeline stage (K*LIMB_W == 255)
//   LIMB_W       bits of b consumed per Horner step
//   ACC_W        Horner accumulator width
//   CNT_W        width of the limb index / stage cycle counter
//   A24          curve constant 121665 shared with the ladder
// ---------------------------------------------------------------------------
package fe25519_pkg;

    localparam int FE_W   = 255;
    localparam int K      = 17;
    localparam int LIMB_W = 15;
    localparam int ACC_W  = 272;
    localparam int CNT_W  = $clog2(K + 1);
    localparam int FOLD_C = 19;

    localparam logic [FE_W-1:0] P           = {FE_W{1'b1}} - 255'd18;
    localparam logic [FE_W-1:0] P_MINUS_TWO = P - 255'd2;
    localparam logic [FE_W-1:0] A24         = 255'd121665;

endpackage

// File: rtl/fe25519_fold.sv
// ---------------------------------------------------------------------------
// fe25519_fold
// Combinational partial reduction: y = x[254:0] + 19 * x[IN_W-1:255].
// Since 2^255 == 19 (mod P), y is congruent to x. For IN_W <= 272 the
// result is below 2^255 + 2^22 and always fits in 256 bits.
//   x  in   IN_W  value to fold (IN_W > 255)
//   y  out  256   folded value
// ---------------------------------------------------------------------------
module fe25519_fold
    import fe25519_pkg::*;
#(
    parameter int IN_W = ACC_W
) (
    input  logic [IN_W-1:0] x,
    output logic [255:0]    y
);

    logic [255:0] lo;
    logic [255:0] hi;

    assign lo = {1'b0, x[FE_W-1:0]};
    assign hi = 256'(x[IN_W-1:FE_W]);
    assign y  = lo + hi * 256'(FOLD_C);

endmodule

// File: rtl/fe25519_mul_pipe.sv
// ---------------------------------------------------------------------------
// fe25519_mul_pipe
// Two-stage field multiplier, out = a*b mod (2^255-19).
//   S1: Horner multiply-accumulate over 15-bit limbs of b, MSB limb first,
//       K steps. The last step writes straight into the S2 register.
//   S2: two folds and one conditional subtract of P, then a hold until the
//       K-th cycle so every result appears exactly 2K cycles after accept.
// Handshake: a request is accepted on any rising edge where start && ready;
// a and b are sampled on that edge. start while ready=0 is ignored, nothing
// is queued. done is a one-cycle pulse; out is held until the next done.
// Ports:
//   clock    in   1    rising-edge clock
//   reset_n  in   1    asynchronous active-low reset, drops in-flight work
//   start    in   1    request
//   a, b     in   255  operands
//   ready    out  1    start will be accepted on the next edge
//   done     out  1    out is valid (one cycle)
//   out      out  255  canonical product
// ---------------------------------------------------------------------------
module fe25519_mul_pipe
    import fe25519_pkg::*;
(
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    input  logic [FE_W-1:0] a,
    input  logic [FE_W-1:0] b,
    output logic            ready,
    output logic            done,
    output logic [FE_W-1:0] out
);

    // ---------------- S1 state ----------------
    logic             s1_busy;
    logic [CNT_W-1:0] j;
    logic [ACC_W-1:0] acc;
    logic [FE_W-1:0]  a_r;
    logic [FE_W-1:0]  b_r;

    // ---------------- S2 state ----------------
    logic             s2_busy;
    logic [CNT_W-1:0] c;
    logic [ACC_W-1:0] r;
    logic [ACC_W-1:0] r_next;

    // ---------------- datapath ----------------
    logic [LIMB_W-1:0]      limb;
    logic [FE_W+LIMB_W-1:0] pp;
    logic [255:0]           acc_fold;
    logic [ACC_W:0]         step_sum;
    logic [255:0]           r_fold_wide;
    logic [255:0]           r_fold_narrow;

    logic accept;
    logic handoff;
    logic s2_done;

    // ready already rises while the final (j=0) step is pending, so a new
    // accept can overlap the handoff edge and throughput is one per K cycles.
    assign ready   = !s1_busy || (j == '0);
    assign accept  = start && ready;
    assign handoff = s1_busy && (j == '0);
    assign s2_done = s2_busy && (c == CNT_W'(K));

    assign limb = LIMB_W'(b_r >> (LIMB_W * int'(j)));
    assign pp   = {{LIMB_W{1'b0}}, a_r} * {{FE_W{1'b0}}, limb};

    fe25519_fold #(.IN_W(ACC_W)) u_fold_s1 (
        .x (acc),
        .y (acc_fold)
    );

    // fold(acc) < 2^255+2^22, so the shifted value plus a 270-bit partial
    // product stays below 2^272; the extra top bit exists only to prove it.
    assign step_sum = {2'b00, acc_fold, {LIMB_W{1'b0}}} + {3'b000, pp};

    // First S2 fold takes the full 272-bit handoff value; the second only
    // sees a 256-bit value, leaving r < 2^255 + 19.
    fe25519_fold #(.IN_W(ACC_W)) u_fold_s2a (
        .x (r),
        .y (r_fold_wide)
    );

    fe25519_fold #(.IN_W(256)) u_fold_s2b (
        .x (r[255:0]),
        .y (r_fold_narrow)
    );

    always_comb begin
        r_next = r;
        if (c == CNT_W'(1)) begin
            r_next = ACC_W'(r_fold_wide);
        end else if (c == CNT_W'(2)) begin
            r_next = ACC_W'(r_fold_narrow);
        end else if (c == CNT_W'(3)) begin
            if (r[255:0] >= {1'b0, P}) begin
                r_next = ACC_W'(r[255:0] - {1'b0, P});
            end
        end
    end

    // ---------------- S1 registers ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_busy <= 1'b0;
            j       <= '0;
            acc     <= '0;
            a_r     <= '0;
            b_r     <= '0;
        end else if (accept) begin
            s1_busy <= 1'b1;
            j       <= CNT_W'(K - 1);
            acc     <= '0;
            a_r     <= a;
            b_r     <= b;
        end else if (s1_busy) begin
            acc <= step_sum[ACC_W-1:0];
            j   <= j - CNT_W'(1);
            if (j == '0) begin
                s1_busy <= 1'b0;
            end
        end
    end

    // ---------------- S2 registers and outputs ----------------
    // On a shared handoff/completion edge, out captures the old r while r
    // loads the new sum; non-blocking semantics give exactly that order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s2_busy <= 1'b0;
            c       <= '0;
            r       <= '0;
            done    <= 1'b0;
            out     <= '0;
        end else begin
            if (handoff) begin
                s2_busy <= 1'b1;
                c       <= CNT_W'(1);
                r       <= step_sum[ACC_W-1:0];
            end else if (s2_busy) begin
                r <= r_next;
                if (s2_done) begin
                    s2_busy <= 1'b0;
                end else begin
                    c <= c + CNT_W'(1);
                end
            end
            done <= s2_done;
            if (s2_done) begin
                out <= r[FE_W-1:0];
            end
        end
    end

    // Horner accumulator must never carry out of ACC_W bits.
    acc_no_overflow: assert property (
        @(posedge clock) disable iff (!reset_n) s1_busy |-> !step_sum[ACC_W]
    );

endmodule

// File: tb/tb_fe25519_mul_pipe.sv
module tb_fe25519_mul_pipe;
    import fe25519_pkg::*;

    localparam int LAT = 2 * K;
    localparam int N_RANDOM = 2000;

    logic            clock = 1'b0;
    logic            reset_n = 1'b1;
    logic            start = 1'b0;
    logic [FE_W-1:0] a = '0;
    logic [FE_W-1:0] b = '0;
    logic            ready;
    logic            done;
    logic [FE_W-1:0] out;

    logic [FE_W-1:0] exp_q[$];
    int              due_q[$];
    int              n_cmp = 0;
    int              n_bad = 0;
    int              cyc = 0;

    fe25519_mul_pipe dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .done    (done),
        .out     (out)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, cycle %0d", cyc);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [FE_W-1:0] ref_mul(input logic [FE_W-1:0] x, input logic [FE_W-1:0] y);
        logic [511:0] prod;
        logic [511:0] rem;
        prod = 512'(x) * 512'(y);
        rem  = prod % 512'(P);
        return rem[FE_W-1:0];
    endfunction

    function automatic logic [FE_W-1:0] rand_fe();
        logic [255:0] w;
        int mode;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
        mode = $urandom_range(0, 3);
        case (mode)
            0:       return P - 255'($urandom_range(1, 1 << 20));
            1:       return 255'($urandom_range(0, 1000));
            default: return w[FE_W-1:0];
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Drive a request at a negedge; the following posedge is the accept edge.
    task automatic issue(input logic [FE_W-1:0] x, input logic [FE_W-1:0] y);
        start = 1'b1;
        a = x;
        b = y;
        exp_q.push_back(ref_mul(x, y));
        due_q.push_back(cyc + 1 + LAT);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic saw_done;
        @(negedge clock);
        reset_n = 1'b0;
        start = 1'b1;
        a = 255'd5;
        b = 255'd7;
        repeat (3) @(negedge clock);
        n_cmp++;
        if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", ready); end
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++;
        if (out !== '0) begin n_bad++; $display("FAIL reset_out: got %h want 0", out); end
        start = 1'b0;
        reset_n = 1'b1;
        next_cycle();
        n_cmp++;
        if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready: got %b want 1", ready); end
        saw_done = 1'b0;
        for (int i = 0; i < 45; i++) begin
            if (done === 1'b1) saw_done = 1'b1;
            next_cycle();
        end
        n_cmp++;
        if (saw_done !== 1'b0) begin n_bad++; $display("FAIL reset_start_ignored: got done=1 want none"); end
    endtask

    task automatic test_basic();
        int t0;
        int m;
        n_cmp++;
        if (ready !== 1'b1) begin n_bad++; $display("FAIL basic_idle_ready: got %b want 1", ready); end
        start = 1'b1;
        a = 255'd2;
        b = 255'd3;
        t0 = cyc + 1;
        next_cycle();
        start = 1'b0;
        for (int i = 0; i < 42; i++) begin
            m = cyc;
            n_cmp++;
            if (ready !== (m >= t0 + K - 1)) begin
                n_bad++; $display("FAIL basic_ready: cycle %0d got %b want %b", m - t0, ready, (m >= t0 + K - 1));
            end
            n_cmp++;
            if (done !== (m == t0 + LAT)) begin
                n_bad++; $display("FAIL basic_done: cycle %0d got %b want %b", m - t0, done, (m == t0 + LAT));
            end
            if (m == t0 + LAT) begin
                n_cmp++;
                if (out !== 255'd6) begin n_bad++; $display("FAIL basic_out: got %h want 6", out); end
            end
            next_cycle();
        end
    endtask

    task automatic test_wrap();
        logic [FE_W-1:0] va[3];
        logic [FE_W-1:0] vb[3];
        logic [FE_W-1:0] vexp[3];
        logic [FE_W-1:0] e;
        int d;
        int idx;
        int seen;
        va[0] = P - 255'd1;  vb[0] = P - 255'd1;  vexp[0] = 255'd1;
        va[1] = '0;          va[1][254] = 1'b1;    vb[1] = 255'd2;  vexp[1] = 255'd19;
        va[2] = '0;          vb[2] = P - 255'd1;  vexp[2] = 255'd0;
        idx = 0;
        seen = 0;
        for (int i = 0; i < 3 * K + LAT + 10; i++) begin
            if (done === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL wrap_done: unexpected done out=%h", out);
                end else begin
                    e = exp_q.pop_front();
                    d = due_q.pop_front();
                    if (out !== vexp[seen] || out !== e || cyc != d) begin
                        n_bad++;
                        $display("FAIL wrap_out[%0d]: got %h at cycle %0d want %h at cycle %0d", seen, out, cyc, vexp[seen], d);
                    end
                    seen++;
                end
            end
            if (ready === 1'b1 && idx < 3) begin
                issue(va[idx], vb[idx]);
                idx++;
            end else begin
                start = 1'b0;
            end
            next_cycle();
        end
        start = 1'b0;
        n_cmp++;
        if (seen != 3) begin n_bad++; $display("FAIL wrap_count: got %0d results want 3", seen); end
        exp_q.delete();
        due_q.delete();
    endtask

    task automatic test_back_to_back();
        int t0;
        int m;
        start = 1'b1;
        a = A24;
        b = 255'd9;
        t0 = cyc + 1;
        next_cycle();
        start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            m = cyc;
            if (m == t0 + LAT) begin
                n_cmp++;
                if (done !== 1'b1 || out !== 255'd1094985) begin
                    n_bad++; $display("FAIL b2b_first: done=%b out=%h want done=1 out=%h", done, out, 255'd1094985);
                end
            end else if (m == t0 + LAT + K) begin
                n_cmp++;
                if (done !== 1'b1 || out !== P - 255'd2) begin
                    n_bad++; $display("FAIL b2b_second: done=%b out=%h want done=1 out=%h", done, out, P - 255'd2);
                end
            end else begin
                n_cmp++;
                if (done !== 1'b0) begin n_bad++; $display("FAIL b2b_done_low: cycle %0d got 1 want 0", m - t0); end
                if (m > t0 + LAT && m < t0 + LAT + K) begin
                    n_cmp++;
                    if (out !== 255'd1094985) begin
                        n_bad++; $display("FAIL b2b_hold: cycle %0d got %h want %h", m - t0, out, 255'd1094985);
                    end
                end
            end
            if (m == t0 + K - 1) begin
                n_cmp++;
                if (ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready: got %b want 1", ready); end
                start = 1'b1;
                a = P - 255'd1;
                b = 255'd2;
            end else begin
                start = 1'b0;
            end
            next_cycle();
        end
        start = 1'b0;
    endtask

    task automatic test_busy_abort();
        logic [FE_W-1:0] e;
        int d;
        int t0;
        int m;
        int n_done;
        logic saw_done;

        // Part 1: a start while busy is ignored
        issue(rand_fe(), rand_fe());
        t0 = cyc + 1;
        next_cycle();
        start = 1'b0;
        n_done = 0;
        for (int i = 0; i < LAT + 12; i++) begin
            m = cyc;
            if (done === 1'b1) begin
                n_done++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL busy_done: unexpected done out=%h", out);
                end else begin
                    e = exp_q.pop_front();
                    d = due_q.pop_front();
                    if (out !== e || cyc != d) begin
                        n_bad++; $display("FAIL busy_out: got %h at cycle %0d want %h at cycle %0d", out, cyc, e, d);
                    end
                end
            end
            if (m == t0 + 4) begin
                n_cmp++;
                if (ready !== 1'b0) begin n_bad++; $display("FAIL busy_ready: got %b want 0", ready); end
                start = 1'b1;
                a = rand_fe();
                b = rand_fe();
            end else begin
                start = 1'b0;
            end
            next_cycle();
        end
        n_cmp++;
        if (n_done != 1) begin n_bad++; $display("FAIL busy_count: got %0d dones want 1", n_done); end

        // Part 2: reset while S2 is working drops the result
        issue(rand_fe(), rand_fe());
        t0 = cyc + 1;
        next_cycle();
        start = 1'b0;
        while (cyc < t0 + K + 2) next_cycle();
        reset_n = 1'b0;
        exp_q.delete();
        due_q.delete();
        repeat (3) next_cycle();
        reset_n = 1'b1;
        n_cmp++;
        if (out !== '0) begin n_bad++; $display("FAIL abort_out: got %h want 0", out); end
        saw_done = 1'b0;
        for (int i = 0; i < LAT + 10; i++) begin
            if (done === 1'b1) saw_done = 1'b1;
            next_cycle();
        end
        n_cmp++;
        if (saw_done !== 1'b0) begin n_bad++; $display("FAIL abort_no_done: got a done want none"); end

        // Part 3: recovery
        issue(rand_fe(), rand_fe());
        next_cycle();
        start = 1'b0;
        for (int i = 0; i < LAT + 5; i++) begin
            if (done === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL recover_done: unexpected done out=%h", out);
                end else begin
                    e = exp_q.pop_front();
                    d = due_q.pop_front();
                    if (out !== e || cyc != d) begin
                        n_bad++; $display("FAIL recover_out: got %h at cycle %0d want %h at cycle %0d", out, cyc, e, d);
                    end
                end
            end
            next_cycle();
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL recover_missing: %0d results pending want 0", exp_q.size());
        end
        exp_q.delete();
        due_q.delete();
    endtask

    task automatic test_random();
        logic [FE_W-1:0] e;
        int d;
        int issued;
        issued = 0;
        for (int i = 0; i < N_RANDOM * K + LAT + 20; i++) begin
            if (done === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL random_done: unexpected done out=%h", out);
                end else begin
                    e = exp_q.pop_front();
                    d = due_q.pop_front();
                    if (out !== e || cyc != d) begin
                        n_bad++; $display("FAIL random_out: got %h at cycle %0d want %h at cycle %0d", out, cyc, e, d);
                    end
                end
            end
            if (ready === 1'b1 && issued < N_RANDOM) begin
                issue(rand_fe(), rand_fe());
                issued++;
            end else begin
                start = 1'b0;
            end
            next_cycle();
        end
        start = 1'b0;
        n_cmp++;
        if (issued != N_RANDOM || exp_q.size() != 0) begin
            n_bad++; $display("FAIL random_drain: issued %0d pending %0d want %0d and 0", issued, exp_q.size(), N_RANDOM);
        end
        exp_q.delete();
        due_q.delete();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        #1;
        test_reset();
        test_basic();
        test_wrap();
        test_back_to_back();
        test_busy_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
